motor_ramp_ctrl: RTL and testbench
==================================

MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

Interface
REQ-001 Parameter RAMP_DIV, default 1000, clk cycles per ramp step (>=2).
REQ-002 Parameter DEAD_CYCLES, default 5000, zero-drive coast cycles before a direction reversal (>=1).
REQ-003 Parameter STALL_CYCLES, default 2000000, maximum cycles between Hall edges while driving (>=2).
REQ-004 clk  input  1  system clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 target  input  8  requested command; bit7 = direction, [6:0] = duty magnitude.
REQ-007 target_valid  input  1  one-cycle strobe; latches target.
REQ-008 h1, h2, h3  input  1 each  raw asynchronous Hall sensor inputs.
REQ-009 stall_clr  input  1  clears the stall/fault state.
REQ-010 cmd  output  8  command to the PWM generator; bit7 = direction, [6:0] = magnitude.
REQ-011 busy  output  1  high when in RAMP_UP, RAMP_DOWN or DEAD.
REQ-012 stalled  output  1  high while in STALL.
REQ-013 hall_err  output  1  latched invalid-Hall-code flag.

Function
REQ-014 The block SHALL hold a latched target (tgt_dir, tgt_mag) and a current drive (cur_dir, cur_mag); cmd = {cur_dir, cur_mag}, forced to 8'h00 whenever cur_mag = 0.
REQ-015 target_valid SHALL latch target on the same edge in any state except STALL, where it is ignored; the newest strobe wins and in-progress ramps retarget immediately.
REQ-016 A prescaler SHALL count 0..RAMP_DIV-1 from reset, free-running; a step tick occurs on the edge where it equals RAMP_DIV-1.
REQ-017 States: IDLE, RAMP_UP, HOLD, RAMP_DOWN, DEAD, STALL.
REQ-018 IDLE (cur_mag = 0): tgt_mag > 0 -> cur_dir <= tgt_dir, go RAMP_UP.
REQ-019 RAMP_UP: each tick cur_mag += 1; cur_mag = tgt_mag -> HOLD; tgt_mag < cur_mag or tgt_dir != cur_dir -> RAMP_DOWN.
REQ-020 HOLD: tgt_mag > cur_mag with same direction -> RAMP_UP; tgt_mag < cur_mag or tgt_dir != cur_dir -> RAMP_DOWN.
REQ-021 RAMP_DOWN: each tick cur_mag -= 1; same direction and cur_mag = tgt_mag > 0 -> HOLD; cur_mag reaches 0 -> DEAD if tgt_mag > 0 and tgt_dir != cur_dir, else IDLE.
REQ-022 tgt_mag = 0 SHALL ignore tgt_dir (no reversal, ramp to 0 then IDLE).
REQ-023 DEAD: cmd = 8'h00 for exactly DEAD_CYCLES cycles, then cur_dir <= tgt_dir and go RAMP_UP (or IDLE if tgt_mag = 0 by then).
REQ-024 cur_mag SHALL change by exactly 1 per tick, never wrap below 0 or above 127.
REQ-025 Hall inputs SHALL pass a 2-flop synchronizer; an edge is any change of the synchronized 3-bit code.
REQ-026 A stall counter SHALL clear on every Hall edge and whenever cur_mag = 0, else increment; reaching STALL_CYCLES -> STALL.
REQ-027 STALL: cur_mag <= 0 on entry edge (cmd = 8'h00 next cycle), stalled = 1, tgt_mag <= 0; stall_clr -> IDLE.
REQ-028 Stall detection SHALL take priority over all other transitions in the same cycle; stall_clr outside STALL has no effect.

Reset
REQ-029 rst SHALL set state IDLE, cmd = 8'h00, cur/tgt = 0, prescaler, dead and stall counters = 0, Hall synchronizers = 0, busy = stalled = hall_err = 0.
REQ-030 rst mid-ramp or mid-DEAD SHALL zero cmd on the next edge with no residual ramp.

Configuration
REQ-031 Macro MOTOR_HALL_CHECK_EN: defined -> a synchronized Hall code of 3'b000 or 3'b111 for 2 consecutive cycles sets hall_err and enters STALL; cleared by stall_clr. Undefined -> hall_err tied 0, no code check.

Verification (RAMP_DIV=4, DEAD_CYCLES=8, STALL_CYCLES=50, Halls toggled every 10 cycles unless stated)
REQ-032 target=8'h05 strobe from IDLE -> cmd 01,02,03,04,05 at 4-cycle spacing, then HOLD, busy falls with cmd=05.
REQ-033 In HOLD at 8'h05, target=8'h83 -> cmd ramps 04..01 to 00, 8 cycles at 00 with busy=1, then 81,82,83.
REQ-034 target=8'h0A then target=8'h03 mid-ramp at cmd=06 -> cmd ramps down 05,04,03, HOLD.
REQ-035 Halls frozen at cmd=05 -> 50 cycles later stalled=1, cmd=00, target strobes ignored; stall_clr -> IDLE, cmd stays 00.
REQ-036 rst asserted during DEAD -> next cycle cmd=00, state IDLE, busy=0.
REQ-037 MOTOR_HALL_CHECK_EN defined, Halls forced 3'b111 while driving -> hall_err=1, stalled=1, cmd=00; undefined -> hall_err stays 0.

Source files
------------

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: slew-limited motor drive command with dead-time on
// direction reversal and Hall-edge stall detection.
// Optional feature macro: MOTOR_HALL_CHECK_EN. When defined, it enables the
// invalid Hall code check (3'b000 / 3'b111), which drives hall_err.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no drive; waits for a non-zero target
// RAMP_UP   | slewing; one magnitude step per prescaler tick toward goal
// HOLD      | drive equals target
// RAMP_DOWN | slewing toward a lower magnitude, or toward 0 to reverse
// DEAD      | zero-drive coast before a direction reversal
// STALL     | drive removed after stall/Hall fault; waits for stall_clr
module motor_ramp_ctrl #(
  parameter int RAMP_DIV     = 1000,
  parameter int DEAD_CYCLES  = 5000,
  parameter int STALL_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] target,
  input  logic       target_valid,
  input  logic       h1,
  input  logic       h2,
  input  logic       h3,
  input  logic       stall_clr,
  output logic [7:0] cmd,
  output logic       busy,
  output logic       stalled,
  output logic       hall_err
);

  localparam int PW = $clog2(RAMP_DIV);
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int SW = $clog2(STALL_CYCLES);
  localparam logic [PW-1:0] PRESC_MAX = PW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RAMP_UP, HOLD, RAMP_DOWN, DEAD, STALL} state_t;

  state_t        state;
  state_t        settle_state;
  logic          tgt_dir, cur_dir;
  logic [6:0]    tgt_mag, cur_mag;
  logic [6:0]    goal, step_mag, end_mag;
  logic          keep_dir, reverse, tick;
  logic [PW-1:0] presc;
  logic [DW-1:0] dead_cnt;
  logic [SW-1:0] stall_cnt;
  logic [2:0]    hall_s1, hall_s2, hall_prev;
  logic          hall_edge, stall_hit, hall_fault;

  // A zero-magnitude target means "stop": its direction bit never forces a reversal.
  assign keep_dir  = (tgt_mag == 7'd0) || (tgt_dir == cur_dir);
  assign reverse   = (tgt_mag != 7'd0) && (tgt_dir != cur_dir);
  assign goal      = keep_dir ? tgt_mag : 7'd0;
  assign step_mag  = (goal > cur_mag) ? cur_mag + 7'd1 : cur_mag - 7'd1;
  assign end_mag   = (cur_mag == goal) ? cur_mag : step_mag;
  assign tick      = (presc == PRESC_MAX);
  assign hall_edge = (hall_s2 != hall_prev);
  assign stall_hit = !hall_edge && (cur_mag != 7'd0) && (stall_cnt == STALL_MAX);

  // Where a ramp comes to rest once it reaches its goal.
  always_comb begin
    settle_state = HOLD;
    if (end_mag == 7'd0) settle_state = reverse ? DEAD : IDLE;
  end

  // Two-flop Hall synchronizer plus previous code for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      hall_s1   <= 3'b000;
      hall_s2   <= 3'b000;
      hall_prev <= 3'b000;
    end else begin
      hall_s1   <= {h3, h2, h1};
      hall_s2   <= hall_s1;
      hall_prev <= hall_s2;
    end
  end

  // Free-running ramp step prescaler.
  always_ff @(posedge clk) begin
    if (rst || tick) presc <= '0;
    else             presc <= presc + PW'(1);
  end

  // Cycles since the last Hall edge while the motor is being driven.
  always_ff @(posedge clk) begin
    if (rst || hall_edge || cur_mag == 7'd0 || stall_hit) stall_cnt <= '0;
    else                                                  stall_cnt <= stall_cnt + SW'(1);
  end

`ifdef MOTOR_HALL_CHECK_EN
  logic code_bad, bad_q, err_q;
  assign code_bad   = (hall_s2 == 3'b000) || (hall_s2 == 3'b111);
  assign hall_fault = code_bad && bad_q && (cur_mag != 7'd0) && (state != STALL);
  assign hall_err   = err_q;

  // Invalid code must persist two synchronized cycles before it is a fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      bad_q <= code_bad;
      if (hall_fault)                    err_q <= 1'b1;
      else if (state == STALL && stall_clr) err_q <= 1'b0;
    end
  end
`else
  assign hall_fault = 1'b0;
  assign hall_err   = 1'b0;
`endif

  // Main sequencer: target latch, ramping, dead time and stall handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tgt_dir  <= 1'b0;
      tgt_mag  <= 7'd0;
      cur_dir  <= 1'b0;
      cur_mag  <= 7'd0;
      dead_cnt <= '0;
    end else begin
      if (target_valid && state != STALL) begin
        tgt_dir <= target[7];
        tgt_mag <= target[6:0];
      end
      if (state != STALL && (stall_hit || hall_fault)) begin
        state   <= STALL;
        cur_mag <= 7'd0;
        tgt_mag <= 7'd0;
      end else begin
        case (state)
          IDLE: begin
            if (tgt_mag != 7'd0) begin
              cur_dir <= tgt_dir;
              state   <= RAMP_UP;
            end
          end
          RAMP_UP, RAMP_DOWN: begin
            dead_cnt <= DEAD_LOAD;
            if (cur_mag == goal) begin
              state <= settle_state;
            end else if (tick) begin
              cur_mag <= step_mag;
              if (step_mag == goal) state <= settle_state;
              else                  state <= (goal > step_mag) ? RAMP_UP : RAMP_DOWN;
            end else begin
              state <= (goal > cur_mag) ? RAMP_UP : RAMP_DOWN;
            end
          end
          HOLD: begin
            if (goal > cur_mag)      state <= RAMP_UP;
            else if (goal < cur_mag) state <= RAMP_DOWN;
          end
          DEAD: begin
            if (dead_cnt == '0) begin
              cur_dir <= tgt_dir;
              state   <= (tgt_mag != 7'd0) ? RAMP_UP : IDLE;
            end else begin
              dead_cnt <= dead_cnt - DW'(1);
            end
          end
          STALL: begin
            if (stall_clr) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign cmd     = (cur_mag == 7'd0) ? 8'h00 : {cur_dir, cur_mag};
  assign busy    = (state == RAMP_UP) || (state == RAMP_DOWN) || (state == DEAD);
  assign stalled = (state == STALL);

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: goal-seeking reference model compared every
// cycle, plus directed sequences with hand-computed literal expectations.
module tb_motor_ramp_ctrl;
  localparam int RD = 4;
  localparam int DC = 8;
  localparam int SC = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] target = 8'h00;
  logic       target_valid = 1'b0;
  logic       h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
  logic       stall_clr = 1'b0;
  logic [7:0] cmd;
  logic       busy, stalled, hall_err;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  motor_ramp_ctrl #(.RAMP_DIV(RD), .DEAD_CYCLES(DC), .STALL_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .target(target), .target_valid(target_valid),
    .h1(h1), .h2(h2), .h3(h3), .stall_clr(stall_clr),
    .cmd(cmd), .busy(busy), .stalled(stalled), .hall_err(hall_err)
  );

  always #5 clk = ~clk;

  // Hall stimulus: valid 6-step commutation sequence, one step per 10 cycles.
  logic [2:0] seq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  bit         hall_run = 1'b0;
  bit         hall_force = 1'b0;
  logic [2:0] hall_force_val = 3'b111;
  int         hidx = 0, hcnt = 0;
  always @(negedge clk) begin
    if (hall_force) {h3, h2, h1} = hall_force_val;
    else if (hall_run) begin
      hcnt++;
      if (hcnt >= 10) begin
        hcnt = 0;
        hidx = (hidx + 1) % 6;
      end
      {h3, h2, h1} = seq[hidx];
    end
  end

  // Reference model: drive magnitude walks toward a goal one unit per tick.
  int         cyc, m_mag, m_tmag, m_dead, m_quiet;
  bit         m_dir, m_tdir, m_moving, m_stalled, m_herr, m_badq;
  logic [2:0] hist0, hist1, hist2;
  always @(posedge clk) begin : model_upd
    int otm, goal;
    bit otd, tk, hedge, bad, hfault, stall_now, rev;
    if (rst) begin
      cyc = 0; m_mag = 0; m_tmag = 0; m_dead = 0; m_quiet = 0;
      m_dir = 0; m_tdir = 0; m_moving = 0; m_stalled = 0; m_herr = 0; m_badq = 0;
      hist0 = 3'b000; hist1 = 3'b000; hist2 = 3'b000;
    end else begin
      tk = (cyc % RD) == RD - 1;
      cyc++;
      hedge = (hist1 != hist2);
      bad = (hist1 == 3'b000) || (hist1 == 3'b111);
      hfault = 1'b0;
`ifdef MOTOR_HALL_CHECK_EN
      hfault = bad && m_badq && (m_mag != 0) && !m_stalled;
`endif
      m_badq = bad;
      stall_now = !m_stalled && (m_mag != 0) && !hedge && (m_quiet == SC - 1);
      m_quiet = (hedge || m_mag == 0 || stall_now) ? 0 : m_quiet + 1;
      hist2 = hist1; hist1 = hist0; hist0 = {h3, h2, h1};
      otm = m_tmag; otd = m_tdir;
      if (target_valid && !m_stalled) begin
        m_tdir = target[7];
        m_tmag = target[6:0];
      end
      goal = (otm == 0 || otd == m_dir) ? otm : 0;
      rev = (otm != 0) && (otd != m_dir);
      if (m_stalled) begin
        if (stall_clr) begin m_stalled = 0; m_herr = 0; end
      end else if (stall_now || hfault) begin
        m_stalled = 1; m_mag = 0; m_tmag = 0; m_moving = 0; m_dead = 0;
        if (hfault) m_herr = 1;
      end else if (m_dead > 0) begin
        if (m_dead == 1) begin m_dead = 0; m_dir = otd; m_moving = (otm != 0); end
        else m_dead--;
      end else if (!m_moving) begin
        if (m_mag == 0) begin
          if (otm != 0) begin m_dir = otd; m_moving = 1; end
        end else if (goal != m_mag) m_moving = 1;
      end else begin
        if (m_mag != goal && tk) m_mag += (goal > m_mag) ? 1 : -1;
        if (m_mag == goal) begin
          m_moving = 0;
          if (m_mag == 0 && rev) m_dead = DC;
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : compare
    logic [7:0] exp_cmd;
    if (chk_en) begin
      exp_cmd = (m_mag == 0) ? 8'h00 : {m_dir, m_mag[6:0]};
      checks++;
      if (cmd !== exp_cmd || busy !== (m_moving || m_dead > 0) ||
          stalled !== m_stalled || hall_err !== m_herr) begin
        failures++;
        $display("FAIL model t=%0t cmd=%h/%h busy=%b/%b stalled=%b/%b hall_err=%b/%b (actual/required)",
                 $time, cmd, exp_cmd, busy, (m_moving || m_dead > 0), stalled, m_stalled, hall_err, m_herr);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] v);
    target = v;
    target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  logic [7:0] rv[$];
  int         rt[$];
  int         rec_end;
  task automatic record_ramp(input string name, input int budget);
    int n;
    logic [7:0] last;
    rv.delete(); rt.delete(); n = 0;
    while (!busy && n < budget) begin @(negedge clk); n++; end
    last = cmd;
    while (busy && n < budget) begin
      @(negedge clk); n++;
      if (cmd !== last) begin rv.push_back(cmd); rt.push_back(n); last = cmd; end
    end
    rec_end = n;
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d cycles required<%0d", name, n, budget);
    end
  endtask

  task automatic check_seq(input string name, input logic [63:0] exp, input int n);
    checks++;
    if (rv.size() != n) begin
      failures++;
      $display("FAIL %s_len actual=%0d required=%0d", name, rv.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        logic [7:0] e;
        e = exp[8*(n-1-i) +: 8];
        check(name, rv[i], e);
      end
    end
  endtask

  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_cmd", cmd, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_stalled", stalled, 0);
    check("rst_hall_err", hall_err, 0);
    rst = 1'b0;
    hall_run = 1'b1;
    repeat (20) @(negedge clk);

    // Ramp up from idle.
    strobe(8'h05);
    record_ramp("ramp_up", 200);
    check_seq("ramp_up", 64'h0102030405, 5);
    if (rt.size() == 5) begin
      for (int i = 1; i < 5; i++) check("ramp_up_spacing", rt[i] - rt[i-1], RD);
      check("busy_fall_with_05", rt[4], rec_end);
    end
    check("hold_cmd", cmd, 8'h05);
    check("hold_busy", busy, 0);

    // Reversal through dead time.
    strobe(8'h83);
    record_ramp("reverse", 300);
    check_seq("reverse", 64'h0403020100818283, 8);
    if (rv.size() == 8) check("dead_gap", rt[5] - rt[4], 12);
    check("rev_hold_cmd", cmd, 8'h83);

    // Zero magnitude with dir bit clear: ramp to idle, no reversal.
    strobe(8'h00);
    record_ramp("to_idle", 300);
    check_seq("to_idle", 64'h828100, 3);

    // Retarget mid-ramp.
    strobe(8'h0A);
    n = 0;
    while (cmd !== 8'h06 && n < 100) begin @(negedge clk); n++; end
    check("reach_06", cmd, 8'h06);
    strobe(8'h03);
    record_ramp("retarget", 200);
    check_seq("retarget", 64'h050403, 3);
    check("retarget_hold", cmd, 8'h03);

    // Hall code 111 burst while driving.
    hall_force = 1'b1;
    repeat (5) @(negedge clk);
    hall_force = 1'b0;
    repeat (5) @(negedge clk);
`ifdef MOTOR_HALL_CHECK_EN
    check("hall_err_set", hall_err, 1);
    check("hall_err_stall", stalled, 1);
    check("hall_err_cmd", cmd, 8'h00);
    stall_clr = 1'b1; @(negedge clk); stall_clr = 1'b0;
    check("hall_err_clr", hall_err, 0);
`else
    check("hall_err_tied", hall_err, 0);
    check("hall_burst_cmd", cmd, 8'h03);
`endif

    // Stall: freeze Halls while holding 05.
    strobe(8'h05);
    record_ramp("pre_stall", 200);
    check("pre_stall_cmd", cmd, 8'h05);
    hall_run = 1'b0;
    n = 0;
    while (!stalled && n < 200) begin @(negedge clk); n++; end
    check("stall_delay_in_range", (n >= SC - 12 && n <= SC + 5), 1);
    check("stall_cmd", cmd, 8'h00);
    check("stall_busy", busy, 0);
    strobe(8'h07);
    repeat (10) @(negedge clk);
    check("stall_ignore_cmd", cmd, 8'h00);
    check("stall_ignore_flag", stalled, 1);
    stall_clr = 1'b1; @(negedge clk); stall_clr = 1'b0;
    check("clr_stalled", stalled, 0);
    repeat (20) @(negedge clk);
    check("clr_cmd", cmd, 8'h00);
    check("clr_busy", busy, 0);
    hall_run = 1'b1;

    // Zero magnitude with dir bit set: no reversal, straight to idle.
    strobe(8'h04);
    record_ramp("up4", 200);
    strobe(8'h80);
    record_ramp("down_dir_ignored", 200);
    check_seq("down_dir_ignored", 64'h03020100, 4);
    check("no_dead_busy", busy, 0);

    // Reset asserted during dead time.
    strobe(8'h02);
    record_ramp("up2", 200);
    strobe(8'h82);
    n = 0;
    while (!(busy && cmd === 8'h00) && n < 100) begin @(negedge clk); n++; end
    check("in_dead", busy && cmd === 8'h00, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_dead_cmd", cmd, 8'h00);
    check("rst_dead_busy", busy, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_cmd", cmd, 8'h00);
    check("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
